// File: rtl/vend_pkg.sv
// Shared coin codes and vending state encodings used by the coin acceptor and the vending FSM.
package vend_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE   = 2'b00;
  localparam coin_t COIN_NICKEL = 2'b01;
  localparam coin_t COIN_DIME   = 2'b10;

  // Vending FSM credit states; kept here so both sides agree on the encoding.
  typedef enum logic [1:0] {
    VEND_IDLE    = 2'b00,
    VEND_FIVE    = 2'b01,
    VEND_TEN     = 2'b10,
    VEND_FIFTEEN = 2'b11
  } vend_state_t;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchroniser, stability-count debouncer and rising-edge pulse for one coin sensor.
module coin_debounce
  import vend_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise_c
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
      // Level only follows the synchronised input after DEB_CYCLES disagreeing samples.
      if (sync2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise_c = level & ~prev;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounces nickel/dime sensors, queues coins, presents one per cycle.
// Optional running totals enabled by defining COIN_ACCEPTOR_TALLY_EN.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    nickel_in,
  input  logic                    dime_in,
  input  logic                    newspaper,
  output coin_t                   coin,
  output logic                    reject,
  output logic [$clog2(DEPTH):0]  fifo_count
`ifdef COIN_ACCEPTOR_TALLY_EN
  ,
  output logic [15:0]             nickel_total,
  output logic [15:0]             dime_total,
  output logic [15:0]             reject_total
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic          nickel_ev;
  logic          dime_ev;
  coin_t         mem [DEPTH];
  logic [CW-1:0] wr_ptr;
  logic [CW-1:0] rd_ptr;
  coin_t         head;
  coin_t         push_code;
  logic          empty;
  logic          full;
  logic          single;
  logic          push;
  logic          pop;
  logic          discard;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_nickel (
    .clock  (clock),
    .reset  (reset),
    .raw    (nickel_in),
    .rise_c (nickel_ev)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dime (
    .clock  (clock),
    .reset  (reset),
    .raw    (dime_in),
    .rise_c (dime_ev)
  );

  // Push/pop arbitration; a full FIFO still accepts when the head leaves this cycle.
  always_comb begin
    empty     = (fifo_count == CW'(0));
    full      = (fifo_count == CW'(DEPTH));
    head      = mem[rd_ptr[AW-1:0]];
    pop       = ~empty & ~newspaper;
    coin      = pop ? head : COIN_NONE;
    single    = nickel_ev ^ dime_ev;
    push_code = nickel_ev ? COIN_NICKEL : COIN_DIME;
    push      = single & (~full | pop);
    discard   = (nickel_ev & dime_ev) | (single & full & ~pop);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= push_code;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      reject     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      reject     <= discard;
    end
  end

`ifdef COIN_ACCEPTOR_TALLY_EN
  // Saturating totals of delivered coins and discarded events.
  always_ff @(posedge clock) begin
    if (reset) begin
      nickel_total <= '0;
      dime_total   <= '0;
      reject_total <= '0;
    end else begin
      if (pop && head == COIN_NICKEL && nickel_total != 16'hFFFF)
        nickel_total <= nickel_total + 16'd1;
      if (pop && head == COIN_DIME && dime_total != 16'hFFFF)
        dime_total <= dime_total + 16'd1;
      if (discard && reject_total != 16'hFFFF)
        reject_total <= reject_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: expected coins are queued at stimulus time and matched on output.
module tb_coin_acceptor;
  import vend_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        nickel_in;
  logic        dime_in;
  logic        newspaper;
  coin_t       coin;
  logic        reject;
  logic [2:0]  fifo_count;
`ifdef COIN_ACCEPTOR_TALLY_EN
  logic [15:0] nickel_total;
  logic [15:0] dime_total;
  logic [15:0] reject_total;
`endif

  int    vectors     = 0;
  int    miscompares = 0;
  int    rej_seen    = 0;
  int    rej_base    = 0;
  bit    started     = 1'b0;
  coin_t sb[$];

  coin_acceptor #(.DEB_CYCLES(4), .DEPTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .nickel_in    (nickel_in),
    .dime_in      (dime_in),
    .newspaper    (newspaper),
    .coin         (coin),
    .reject       (reject),
    .fifo_count   (fifo_count)
`ifdef COIN_ACCEPTOR_TALLY_EN
    ,
    .nickel_total (nickel_total),
    .dime_total   (dime_total),
    .reject_total (reject_total)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold one sensor high long enough to debounce, then low long enough to settle.
  task automatic pulse(input bit dime);
    if (dime) dime_in = 1'b1; else nickel_in = 1'b1;
    step(8);
    dime_in   = 1'b0;
    nickel_in = 1'b0;
    step(8);
  endtask

  // Output monitor: every non-zero coin must match the oldest expected entry.
  always @(negedge clock) begin
    if (started) begin
      if (reject === 1'b1) rej_seen++;
      if (coin !== COIN_NONE) begin
        if (sb.size() == 0) begin
          chk("unexpected_coin", 32'(coin), 32'(COIN_NONE));
        end else begin
          chk("coin_order", 32'(coin), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    nickel_in = 1'b0;
    dime_in   = 1'b0;
    newspaper = 1'b0;
    step(3);
    reset = 1'b0;
    @(negedge clock);
    chk("reset_coin", 32'(coin), 32'(COIN_NONE));
    chk("reset_reject", 32'(reject), 32'(0));
    chk("reset_count", 32'(fifo_count), 32'(0));
    started = 1'b1;
    step(1);

    // Clean nickel: coin appears exactly in the cycle after edge 6.
    sb.push_back(COIN_NICKEL);
    nickel_in = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("nickel_early", 32'(coin), 32'(COIN_NONE));
    @(posedge clock);
    @(negedge clock);
    chk("nickel_latency", 32'(coin), 32'(COIN_NICKEL));
    chk("nickel_count1", 32'(fifo_count), 32'(1));
    @(posedge clock);
    @(negedge clock);
    chk("nickel_one_cycle", 32'(coin), 32'(COIN_NONE));
    chk("nickel_count0", 32'(fifo_count), 32'(0));
    step(1);
    nickel_in = 1'b0;
    step(10);

    // Bounce: toggling dime is ignored, then one dime is accepted.
    rej_base = rej_seen;
    sb.push_back(COIN_DIME);
    for (int i = 0; i < 10; i++) begin
      dime_in = ~dime_in;
      step(1);
    end
    dime_in = 1'b1;
    step(8);
    dime_in = 1'b0;
    step(12);
    chk("bounce_drained", 32'(sb.size()), 32'(0));
    chk("bounce_no_reject", 32'(rej_seen - rej_base), 32'(0));

    // Simultaneous nickel and dime: one reject, nothing queued.
    rej_base  = rej_seen;
    nickel_in = 1'b1;
    dime_in   = 1'b1;
    step(12);
    chk("simul_reject", 32'(rej_seen - rej_base), 32'(1));
    chk("simul_count", 32'(fifo_count), 32'(0));
    nickel_in = 1'b0;
    dime_in   = 1'b0;
    step(10);

    // Dispense hold: coins wait while newspaper is high.
    newspaper = 1'b1;
    sb.push_back(COIN_DIME);
    pulse(1'b1);
    sb.push_back(COIN_NICKEL);
    pulse(1'b0);
    step(5);
    @(negedge clock);
    chk("hold_coin", 32'(coin), 32'(COIN_NONE));
    chk("hold_count", 32'(fifo_count), 32'(2));
    step(1);
    newspaper = 1'b0;
    @(negedge clock);
    chk("release_first", 32'(coin), 32'(COIN_DIME));
    @(negedge clock);
    chk("release_second", 32'(coin), 32'(COIN_NICKEL));
    @(negedge clock);
    chk("release_empty", 32'(fifo_count), 32'(0));
    step(2);

    // Overflow: fifth queued nickel is rejected.
    rej_base  = rej_seen;
    newspaper = 1'b1;
    for (int i = 0; i < 5; i++) pulse(1'b0);
    for (int i = 0; i < 4; i++) sb.push_back(COIN_NICKEL);
    @(negedge clock);
    chk("overflow_count", 32'(fifo_count), 32'(4));
    chk("overflow_reject", 32'(rej_seen - rej_base), 32'(1));
    step(1);
    newspaper = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("drain_burst", 32'(coin), 32'(COIN_NICKEL));
    end
    @(negedge clock);
    chk("drain_empty", 32'(fifo_count), 32'(0));
    chk("drain_sb", 32'(sb.size()), 32'(0));
    step(2);

`ifdef COIN_ACCEPTOR_TALLY_EN
    chk("tally_nickel", 32'(nickel_total), 32'(6));
    chk("tally_dime", 32'(dime_total), 32'(2));
    chk("tally_reject", 32'(reject_total), 32'(2));
`endif

    // Reset mid-queue discards held coins.
    newspaper = 1'b1;
    pulse(1'b0);
    pulse(1'b1);
    pulse(1'b0);
    @(negedge clock);
    chk("preset_count", 32'(fifo_count), 32'(3));
    step(1);
    reset = 1'b1;
    step(1);
    reset     = 1'b0;
    newspaper = 1'b0;
    @(negedge clock);
    chk("midreset_coin", 32'(coin), 32'(COIN_NONE));
    chk("midreset_count", 32'(fifo_count), 32'(0));
`ifdef COIN_ACCEPTOR_TALLY_EN
    chk("midreset_nickel_total", 32'(nickel_total), 32'(0));
    chk("midreset_dime_total", 32'(dime_total), 32'(0));
    chk("midreset_reject_total", 32'(reject_total), 32'(0));
`endif
    step(12);
    chk("postreset_count", 32'(fifo_count), 32'(0));
    chk("final_sb", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage that feeds the newspaper vending FSM.
- Takes raw, bouncy nickel and dime sensor lines, then synchronises, debounces and edge-detects them.
- Queues accepted coins in a small FIFO and presents them one per cycle as the 2-bit coin code the vending FSM consumes (01 = nickel, 10 = dime, 00 = none).
- Withholds coins while the vending FSM is dispensing, because the FSM ignores coin input in that state.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised cycles required before a debounced level changes (>=2).
- DEPTH, 4: coin FIFO entries (power of 2, >=2).

Ports:
- clock, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- nickel_in, input, 1: raw asynchronous nickel sensor, high while a coin passes.
- dime_in, input, 1: raw asynchronous dime sensor.
- newspaper, input, 1: dispense indication from the vending FSM; high = coin input ignored this cycle.
- coin, output, 2: coin code to the vending FSM; non-zero for exactly one cycle per accepted coin.
- reject, output, 1: one-cycle pulse when a detected coin event is discarded.
- fifo_count, output, clog2(DEPTH)+1: current FIFO occupancy.

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset: coin=00, reject=0, fifo_count=0. Synchronisers, debounced levels and edge-detect history all clear to 0. FIFO pointers clear to 0. Reset mid-operation discards queued coins.
- Synchroniser: 2-flop chain per sensor.
- Debounce, per sensor:
  - Counter increments while the synchronised value differs from the debounced level.
  - Counter clears when the values agree.
  - When the counter equals DEB_CYCLES-1 and the values still differ, the debounced level flips and the counter clears.
- Event: rising edge of the debounced level, i.e. level=1 and previous=0. Falling edges generate nothing.
- Push:
  - Nickel event alone pushes code 01; dime event alone pushes 10.
  - Nickel and dime events in the same cycle: neither is pushed, reject=1.
  - Event while FIFO is full and no pop in the same cycle: not pushed, reject=1.
  - Full with a simultaneous pop: the push is accepted.
- Pop:
  - coin = FIFO head when FIFO is non-empty and newspaper=0, else 00; this output is combinational from registered state and newspaper.
  - Pop occurs in exactly the cycle coin is non-zero.
  - While newspaper=1 the head is held and coin=00.
- Simultaneous push and pop: both occur; fifo_count is unchanged.
- Pointers: clog2(DEPTH)+1 bits with wrap-around. Full = count==DEPTH; empty = count==0.
- Latency: edge 0 is the first rising edge that samples a raw sensor high, with the sensor held high thereafter.
  - Debounced level flips at edge DEB_CYCLES+1.
  - Push at edge DEB_CYCLES+2.
  - With FIFO empty and newspaper=0, coin is non-zero in the cycle after edge DEB_CYCLES+2.
- Raw pulses shorter than DEB_CYCLES synchronised cycles are ignored.
- One coin is presented per cycle maximum. Back-to-back pops are allowed.

Optional Feature:
- Macro: COIN_ACCEPTOR_TALLY_EN.
- When defined:
  - Adds outputs nickel_total [15:0], dime_total [15:0] and reject_total [15:0].
  - Each increments on a pop of its code, or on a reject pulse, respectively.
  - Each saturates at 16'hFFFF and clears on reset.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package vend_pkg holds:
  - Coin code constants COIN_NONE=2'b00, COIN_NICKEL=2'b01, COIN_DIME=2'b10.
  - A 2-bit coin_t typedef.
  - The vending state encodings, so the FSM and acceptor agree.
- Sub-module coin_debounce (parameter DEB_CYCLES): one synchroniser, debounce counter and rising-edge pulse; instantiated twice.
- FIFO is inline.

Test Plan (DEB_CYCLES=4, DEPTH=4):
- Clean nickel: nickel_in high from edge 0, newspaper=0 -> coin=01 for exactly one cycle, in the cycle after edge 6; fifo_count returns to 0.
- Bounce: dime_in toggles every cycle for 10 cycles, then high 8 cycles -> exactly one coin=10; no reject.
- Simultaneous: nickel_in and dime_in rise together and are held -> one reject pulse, coin stays 00, fifo_count=0.
- Dispense hold: queue dime, nickel with newspaper=1 for 5 cycles -> coin=00 throughout, fifo_count=2. Release -> coin=10 then 01 on consecutive cycles.
- Overflow: newspaper=1, five separate nickel events -> fifo_count=4, one reject on the fifth event. Release -> four 01 pulses.
- Reset mid-queue: 3 coins queued, reset one cycle -> coin=00, fifo_count=0, no coins emitted afterwards. With COIN_ACCEPTOR_TALLY_EN, totals read 0.
